clk_div_period_meter: RTL and testbench

Downstream monitor for the bank of clock-divider outputs. It takes the CHANNELS divided-clock signals, all generated from flops on iClk, and turns each into a one-cycle rising-edge tick. Per channel it measures the period and the high time in iClk cycles. Software or a debug controller reads any channel's latest measurement through a request/acknowledge port, which lets the team confirm the divider ratios in hardware.

---
 rtl/clk_div_period_meter_pkg.sv | 13 +
 rtl/clk_div_period_meter_if.sv | 35 +++
 rtl/clk_div_period_chan.sv | 88 ++++++++
 rtl/clk_div_period_meter.sv | 75 +++++++
 tb/tb_clk_div_period_meter.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_div_period_meter_pkg.sv
// clk_div_period_meter_pkg: shared channel state type and counter constants
package clk_div_period_meter_pkg;

    localparam int DEF_CNT_BITS = 16;
    localparam logic [DEF_CNT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEAS
    } chanState_t;

endpackage

// File: rtl/clk_div_period_meter_if.sv
// clk_div_period_meter_if: request/acknowledge readout port of the period meter
interface clk_div_period_meter_if #(
    parameter int SEL_BITS = 2,
    parameter int CNT_BITS = 16
) ();

    logic                iReq;
    logic [SEL_BITS-1:0] ivSel;
    logic                oAck;
    logic                oValid;
    logic                oOverflow;
    logic [CNT_BITS-1:0] ovPeriod;
    logic [CNT_BITS-1:0] ovHigh;

    modport master (
        output iReq,
        output ivSel,
        input  oAck,
        input  oValid,
        input  oOverflow,
        input  ovPeriod,
        input  ovHigh
    );

    modport slave (
        input  iReq,
        input  ivSel,
        output oAck,
        output oValid,
        output oOverflow,
        output ovPeriod,
        output ovHigh
    );

endinterface

// File: rtl/clk_div_period_chan.sv
// clk_div_period_chan: edge tick, period/high-time measurement and latched results for one divided clock
module clk_div_period_chan
    import clk_div_period_meter_pkg::*;
#(
    parameter int CNT_BITS = DEF_CNT_BITS
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iClkDiv,
    output logic                oTick,
    output logic                oValid,
    output logic                oOverflow,
    output logic [CNT_BITS-1:0] ovPeriod,
    output logic [CNT_BITS-1:0] ovHigh
);

    localparam logic [CNT_BITS-1:0] cntMax = '1;
    localparam logic [CNT_BITS-1:0] cntOne = CNT_BITS'(1);

    chanState_t          rState;
    chanState_t          stateNext;
    logic                rPrev;
    logic                rEdge;
    logic                latch;
    logic [CNT_BITS-1:0] rCnt;
    logic [CNT_BITS-1:0] rHigh;
    logic [CNT_BITS-1:0] cntNext;
    logic [CNT_BITS-1:0] highNext;

    assign rEdge = iClkDiv & ~rPrev;

    // Next state and counter values; an edge while counting closes the period and restarts both counters
    always_comb begin
        stateNext = rState;
        cntNext   = rCnt;
        highNext  = rHigh;
        latch     = 1'b0;
        case (rState)
            IDLE: begin
                if (rEdge) begin
                    stateNext = ARMED;
                    cntNext   = cntOne;
                    highNext  = cntOne;
                end
            end
            ARMED, MEAS: begin
                if (rEdge) begin
                    stateNext = MEAS;
                    latch     = 1'b1;
                    cntNext   = cntOne;
                    highNext  = cntOne;
                end else begin
                    cntNext  = (rCnt == cntMax) ? rCnt : rCnt + 1'b1;
                    highNext = (iClkDiv && rHigh != cntMax) ? rHigh + 1'b1 : rHigh;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State, counters, edge history, tick and the latched measurement
    always_ff @(posedge iClk) begin
        if (iRst) begin
            rState    <= IDLE;
            rPrev     <= 1'b0;
            oTick     <= 1'b0;
            rCnt      <= '0;
            rHigh     <= '0;
            oValid    <= 1'b0;
            oOverflow <= 1'b0;
            ovPeriod  <= '0;
            ovHigh    <= '0;
        end else begin
            rState <= stateNext;
            rPrev  <= iClkDiv;
            oTick  <= rEdge;
            rCnt   <= cntNext;
            rHigh  <= highNext;
            if (latch) begin
                ovPeriod  <= rCnt;
                ovHigh    <= rHigh;
                oValid    <= 1'b1;
                oOverflow <= (rCnt == cntMax) || (rHigh == cntMax);
            end
        end
    end

endmodule

// File: rtl/clk_div_period_meter.sv
// clk_div_period_meter: per-channel period/high-time monitor for divided clocks with a request/ack readout
module clk_div_period_meter
    import clk_div_period_meter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_BITS = DEF_CNT_BITS,
    parameter int SEL_BITS = 2
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic [CHANNELS-1:0] ivClkDiv,
    output logic [CHANNELS-1:0] ovTick,
    clk_div_period_meter_if.slave bus
);

    logic [CHANNELS-1:0] chValid;
    logic [CHANNELS-1:0] chOverflow;
    logic [CNT_BITS-1:0] chPeriod [CHANNELS];
    logic [CNT_BITS-1:0] chHigh   [CHANNELS];
    logic                selValid;
    logic                selOverflow;
    logic [CNT_BITS-1:0] selPeriod;
    logic [CNT_BITS-1:0] selHigh;

    for (genvar i = 0; i < CHANNELS; i++) begin : gChan
        clk_div_period_chan #(
            .CNT_BITS(CNT_BITS)
        ) uChan (
            .iClk     (iClk),
            .iRst     (iRst),
            .iClkDiv  (ivClkDiv[i]),
            .oTick    (ovTick[i]),
            .oValid   (chValid[i]),
            .oOverflow(chOverflow[i]),
            .ovPeriod (chPeriod[i]),
            .ovHigh   (chHigh[i])
        );
    end

    // Readout mux; a select with no matching channel reads as all zeros
    always_comb begin
        selValid    = 1'b0;
        selOverflow = 1'b0;
        selPeriod   = '0;
        selHigh     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (bus.ivSel == SEL_BITS'(k)) begin
                selValid    = chValid[k];
                selOverflow = chOverflow[k];
                selPeriod   = chPeriod[k];
                selHigh     = chHigh[k];
            end
        end
    end

    // Acknowledge one cycle after a request, capturing the channel results as they stood before this edge
    always_ff @(posedge iClk) begin
        if (iRst) begin
            bus.oAck      <= 1'b0;
            bus.oValid    <= 1'b0;
            bus.oOverflow <= 1'b0;
            bus.ovPeriod  <= '0;
            bus.ovHigh    <= '0;
        end else begin
            bus.oAck <= bus.iReq;
            if (bus.iReq) begin
                bus.oValid    <= selValid;
                bus.oOverflow <= selOverflow;
                bus.ovPeriod  <= selPeriod;
                bus.ovHigh    <= selHigh;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_period_meter.sv
// tb_clk_div_period_meter: scoreboard bench for the divided-clock period meter
module tb_clk_div_period_meter;

    typedef struct {
        string tag;
        logic  valid;
        logic  ovf;
        int    period;
        int    high;
    } expT;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] div;
    logic [3:0] tickA;
    logic [3:0] tickB;
    int         per [8];
    int         hi  [8];
    int         ph  [8];
    logic       lvl [8];
    int         nChecks = 0;
    int         nFails = 0;
    expT        qA [$];
    expT        qB [$];

    clk_div_period_meter_if #(.SEL_BITS(3), .CNT_BITS(16)) busA ();
    clk_div_period_meter_if #(.SEL_BITS(2), .CNT_BITS(4))  busB ();

    clk_div_period_meter #(.CHANNELS(4), .CNT_BITS(16), .SEL_BITS(3)) dutA (
        .iClk    (clk),
        .iRst    (rst),
        .ivClkDiv(div[3:0]),
        .ovTick  (tickA),
        .bus     (busA)
    );

    clk_div_period_meter #(.CHANNELS(4), .CNT_BITS(4), .SEL_BITS(2)) dutB (
        .iClk    (clk),
        .iRst    (rst),
        .ivClkDiv(div[7:4]),
        .ovTick  (tickB),
        .bus     (busB)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Divided-clock generator: changes inputs on the falling edge, high while phase < hi
    initial begin
        for (int i = 0; i < 8; i++) begin
            per[i] = 0;
            hi[i]  = 0;
            ph[i]  = 0;
            lvl[i] = 1'b0;
        end
        div = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (per[i] == 0) begin
                    div[i] = lvl[i];
                end else begin
                    div[i] = (ph[i] < hi[i]);
                    ph[i]  = (ph[i] + 1) % per[i];
                end
            end
        end
    end

    // Scoreboard for DUT A: every acknowledge pops one expected read
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (busA.oAck) begin
                if (qA.size() == 0) begin
                    chk("A.unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = qA.pop_front();
                    chk({e.tag, ".valid"}, 32'(busA.oValid), 32'(e.valid));
                    chk({e.tag, ".overflow"}, 32'(busA.oOverflow), 32'(e.ovf));
                    chk({e.tag, ".period"}, 32'(busA.ovPeriod), e.period);
                    chk({e.tag, ".high"}, 32'(busA.ovHigh), e.high);
                end
            end
        end
    end

    // Scoreboard for DUT B
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (busB.oAck) begin
                if (qB.size() == 0) begin
                    chk("B.unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = qB.pop_front();
                    chk({e.tag, ".valid"}, 32'(busB.oValid), 32'(e.valid));
                    chk({e.tag, ".overflow"}, 32'(busB.oOverflow), 32'(e.ovf));
                    chk({e.tag, ".period"}, 32'(busB.ovPeriod), e.period);
                    chk({e.tag, ".high"}, 32'(busB.ovHigh), e.high);
                end
            end
        end
    end

    task automatic setChan(input int i, input int p, input int h, input logic l);
        per[i] = p;
        hi[i]  = h;
        ph[i]  = 0;
        lvl[i] = l;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushA(input string tag, input logic v, input logic o, input int p, input int h);
        expT e;
        e.tag = tag;
        e.valid = v;
        e.ovf = o;
        e.period = p;
        e.high = h;
        qA.push_back(e);
    endtask

    task automatic readA(input string tag, input int sel, input logic v, input logic o, input int p, input int h);
        pushA(tag, v, o, p, h);
        busA.iReq  = 1'b1;
        busA.ivSel = 3'(sel);
        @(posedge clk);
        #1;
        busA.iReq = 1'b0;
    endtask

    task automatic readB(input string tag, input int sel, input logic v, input logic o, input int p, input int h);
        expT e;
        e.tag = tag;
        e.valid = v;
        e.ovf = o;
        e.period = p;
        e.high = h;
        qB.push_back(e);
        busB.iReq  = 1'b1;
        busB.ivSel = 2'(sel);
        @(posedge clk);
        #1;
        busB.iReq = 1'b0;
    endtask

    task automatic waitTickA(input string tag, input int ch);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (tickA[ch]) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic tickStats(input bit isB, input int ch, input int n, output int cnt, output int dbl, output int gap);
        logic t;
        logic prevT;
        int   last;
        cnt   = 0;
        dbl   = 0;
        gap   = 0;
        prevT = 1'b0;
        last  = -1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            t = isB ? tickB[ch] : tickA[ch];
            if (t) begin
                cnt++;
                if (last >= 0) gap = k - last;
                last = k;
            end
            if (t && prevT) dbl++;
            prevT = t;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        int   dbl;
        int   gap;
        bit   found;
        logic prevV;
        rst        = 1'b1;
        busA.iReq  = 1'b0;
        busA.ivSel = '0;
        busB.iReq  = 1'b0;
        busB.ivSel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst.tickA", 32'(tickA), 32'd0);
        chk("rst.tickB", 32'(tickB), 32'd0);
        chk("rst.ackA", 32'(busA.oAck), 32'd0);
        chk("rst.validA", 32'(busA.oValid), 32'd0);
        chk("rst.periodA", 32'(busA.ovPeriod), 32'd0);
        readA("rst_read_ch0", 0, 1'b0, 1'b0, 0, 0);
        cycles(2);
        setChan(0, 16, 8, 1'b0);
        cycles(52);
        readA("ch0_p16", 0, 1'b1, 1'b0, 16, 8);
        tickStats(1'b0, 0, 64, cnt, dbl, gap);
        chk("tick0.count", cnt, 4);
        chk("tick0.double", dbl, 0);
        chk("tick0.interval", gap, 16);
        chk("hold.period", 32'(busA.ovPeriod), 32'd16);
        chk("hold.ack_low", 32'(busA.oAck), 32'd0);
        setChan(3, 12, 6, 1'b0);
        setChan(1, 60, 30, 1'b0);
        setChan(2, 256, 128, 1'b0);
        cycles(780);
        readA("ch3_p12", 3, 1'b1, 1'b0, 12, 6);
        readA("ch1_p60", 1, 1'b1, 1'b0, 60, 30);
        readA("ch2_p256", 2, 1'b1, 1'b0, 256, 128);
        readA("ch0_again", 0, 1'b1, 1'b0, 16, 8);
        cycles(2);
        setChan(4, 20, 10, 1'b0);
        setChan(5, 0, 0, 1'b1);
        cycles(70);
        readB("B_sat_p20", 0, 1'b1, 1'b1, 15, 10);
        readB("B_stuck_high", 1, 1'b0, 1'b0, 0, 0);
        tickStats(1'b1, 1, 30, cnt, dbl, gap);
        chk("B_stuck.ticks", cnt, 0);
        setChan(4, 8, 4, 1'b0);
        cycles(30);
        readB("B_p8", 0, 1'b1, 1'b0, 8, 4);
        waitTickA("pre_rst.tick", 0);
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        readA("after_rst", 0, 1'b0, 1'b0, 0, 0);
        waitTickA("post_rst.first_tick", 0);
        readA("first_edge_only", 0, 1'b0, 1'b0, 0, 0);
        cycles(20);
        readA("recovered", 0, 1'b1, 1'b0, 16, 8);
        waitTickA("pre_rst2.tick", 0);
        cycles(10);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        waitTickA("post_rst2.first_tick", 0);
        found = 1'b0;
        prevV = div[0];
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            #1;
            if (div[0] && !prevV) found = 1'b1;
            prevV = div[0];
        end
        chk("same_cycle.edge_found", 32'(found), 32'd1);
        if (found) begin
            pushA("same_cycle_old", 1'b0, 1'b0, 0, 0);
            busA.iReq  = 1'b1;
            busA.ivSel = 3'd0;
            @(posedge clk);
            #1;
            pushA("sel_out_of_range", 1'b0, 1'b0, 0, 0);
            busA.ivSel = 3'd4;
            @(posedge clk);
            #1;
            busA.iReq = 1'b0;
        end
        cycles(2);
        readA("after_latch", 0, 1'b1, 1'b0, 16, 8);
        for (int k = 0; k < 10 && (qA.size() + qB.size()) != 0; k++) @(posedge clk);
        cycles(2);
        chk("scoreboard.drained", qA.size() + qB.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
